// File: rtl/led_animation_ctrl.sv
// led_animation_ctrl: one-shot 5-LED sweep-left / sweep-right / flash sequencer with registered output.
// Define LED_ANIM_LOOP_EN to restart the sequence back-to-back while active is held high.
module led_animation_ctrl #(
    parameter int STEP_CYCLES = 3,
    parameter int FLASH_COUNT = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       active,
    output logic [4:0] led
);
    localparam int TOTAL = 9 + 2 * FLASH_COUNT;
    localparam int CW    = $clog2(STEP_CYCLES + 1);
    localparam int FW    = $clog2(TOTAL);

    typedef enum logic [1:0] {IDLE, SWEEP_L, SWEEP_R, FLASH} state_t;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cyc, w_cyc_nxt;
    logic [FW-1:0] r_frame, w_frame_nxt, w_frame_inc;
    logic [4:0]    r_led, w_led_nxt;
    logic [2:0]    w_sh;
    logic          r_active_q, w_start, w_wrap, w_last, w_loop;

    assign w_start     = active & ~r_active_q;
    assign w_wrap      = r_cyc == CW'(STEP_CYCLES - 1);
    assign w_last      = r_frame == FW'(TOTAL - 1);
    assign w_frame_inc = r_frame + FW'(1);
    assign led         = r_led;

`ifdef LED_ANIM_LOOP_EN
    assign w_loop = active;
`else
    assign w_loop = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_cyc      <= '0;
            r_frame    <= '0;
            r_led      <= '0;
            r_active_q <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cyc      <= w_cyc_nxt;
            r_frame    <= w_frame_nxt;
            r_led      <= w_led_nxt;
            r_active_q <= active;
        end
    end

    // One global frame index 0..TOTAL-1 spans all three phases.
    always_comb begin
        w_state_nxt = r_state;
        w_frame_nxt = r_frame;
        w_cyc_nxt   = r_cyc;
        if (r_state == IDLE) begin
            w_cyc_nxt   = '0;
            w_frame_nxt = '0;
            w_state_nxt = w_start ? SWEEP_L : IDLE;
        end else if (!w_wrap) begin
            w_cyc_nxt = r_cyc + CW'(1);
        end else begin
            w_cyc_nxt   = '0;
            w_frame_nxt = w_last ? '0 : w_frame_inc;
            w_state_nxt = w_last ? (w_loop ? SWEEP_L : IDLE) :
                          w_frame_inc == FW'(5) ? SWEEP_R :
                          w_frame_inc == FW'(9) ? FLASH : r_state;
        end
    end

    // Sweep-right frames 5..8 light bit (8 - frame), i.e. -frame modulo 8.
    always_comb begin
        w_sh      = w_state_nxt == SWEEP_L ? w_frame_nxt[2:0] : 3'd0 - w_frame_nxt[2:0];
        w_led_nxt = w_state_nxt == IDLE  ? 5'b00000 :
                    w_state_nxt == FLASH ? {5{w_frame_nxt[0]}} : 5'b00001 << w_sh;
    end
endmodule

// File: tb/tb_led_animation_ctrl.sv
// tb_led_animation_ctrl: scoreboard bench for led_animation_ctrl with default parameters.
module tb_led_animation_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       active = 1'b0;
    logic [4:0] led;
    int         n_checks = 0;
    int         n_fail = 0;
    logic [4:0] exp_q[$];
    logic [4:0] frames[13] = '{5'h01, 5'h02, 5'h04, 5'h08, 5'h10, 5'h08, 5'h04,
                               5'h02, 5'h01, 5'h1F, 5'h00, 5'h1F, 5'h00};

    led_animation_ctrl dut (.clk(clk), .reset(reset), .active(active), .led(led));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_anim(input int n = 39);
        for (int i = 0; i < n; i++) exp_q.push_back(frames[i / 3]);
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(5'h00);
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        if (exp_q.size() != 0) chk("led", 32'(led), 32'(exp_q.pop_front()));
    end

    initial begin
        push_idle(4);
        repeat (4) begin
            @(posedge clk);
            #2;
            active = ~active;
        end
        reset = 1'b1;
        push_idle(4);
        run(4);
        // single pulse
        push_anim();
        push_idle(3);
        active = 1'b1;
        run(1);
        active = 1'b0;
        run(41);
`ifdef LED_ANIM_LOOP_EN
        push_anim();
        push_anim();
        push_idle(3);
        active = 1'b1;
        run(50);
        active = 1'b0;
        run(31);
`else
        push_anim();
        push_idle(21);
        active = 1'b1;
        run(60);
        active = 1'b0;
        push_idle(3);
        run(3);
`endif
        // retrigger mid-sequence is ignored
        push_anim();
        push_idle(3);
        active = 1'b1;
        run(1);
        active = 1'b0;
        run(9);
        active = 1'b1;
        run(1);
        active = 1'b0;
        run(31);
        // async reset during SWEEP_R
        push_anim(18);
        active = 1'b1;
        run(1);
        active = 1'b0;
        run(17);
        chk("pre_rst_sweep_r", 32'(led), 32'h08);
        #1;
        reset = 1'b0;
        #1;
        chk("async_rst", 32'(led), 32'h00);
        push_idle(6);
        run(2);
        reset = 1'b1;
        run(4);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/led_animation_ctrl.md
Name: led_animation_ctrl

Overview:
- One-shot 5-LED light-show sequencer for the board's status LEDs.
- A rising edge on `active` starts a fixed animation: sweep left, sweep right, then flash all LEDs.
- After the animation the block returns to idle with all LEDs off.
- Sits between the game/control FSM, which pulses `active`, and the LED pins. Output is fully registered.

Parameters:
- STEP_CYCLES, 3, clock cycles each animation frame is held (legal ≥1).
- FLASH_COUNT, 2, number of all-on/all-off flash pairs at the end of the sequence (legal ≥1).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- active  input  1  start request; synchronous to clk; only its rising edge matters.
- led  output  5  registered LED drive; bit 0 is the rightmost LED.

Behaviour:
- Reset (reset=0, asynchronous):
  - led=5'b00000, state=IDLE, frame counter=0, cycle counter=0.
  - Edge-detect register active_q=0.
  - Applies immediately, including mid-animation; the animation is abandoned.
- Start detection:
  - start = active & ~active_q, evaluated at a clk rising edge.
  - active_q <= active every cycle.
  - active held high gives exactly one start.
  - active already high when reset deasserts gives one start on the first edge.
- States: IDLE, SWEEP_L, SWEEP_R, FLASH.
- IDLE:
  - led=0.
  - On start: go to SWEEP_L; led<=00001 at that same edge (zero-cycle latency from the sampling edge).
  - cycle counter=0.
- Frame timing:
  - Each frame is held exactly STEP_CYCLES cycles.
  - The cycle counter counts 0..STEP_CYCLES-1; the frame advances when it wraps.
- SWEEP_L:
  - Frames 00001, 00010, 00100, 01000, 10000 (5 frames).
  - After 10000: go to SWEEP_R with led=01000.
- SWEEP_R:
  - Frames 01000, 00100, 00010, 00001 (4 frames).
  - After 00001: go to FLASH with led=11111.
- FLASH:
  - Alternates 11111, 00000, repeated FLASH_COUNT times (2×FLASH_COUNT frames).
  - After the final 00000 frame: go to IDLE.
- Sequence length:
  - Total frames = 9 + 2×FLASH_COUNT.
  - Default total = 13 frames = 39 cycles from start edge to IDLE.
- Start while not IDLE: ignored (no restart, no queuing). active_q still tracks active.
- Counter widths: $clog2(STEP_CYCLES+1) for cycles; frame counter sized for 9+2×FLASH_COUNT. No overflow is possible.
- led never shows any value outside the listed patterns.

Optional Feature:
- Macro: LED_ANIM_LOOP_EN.
- Defined:
  - When the sequence ends (final flash-off frame completes) and active is high at that edge, restart directly at SWEEP_L with led=00001.
  - The animation therefore loops continuously while active is held.
  - Releasing active lets the current pass finish, then the block goes to IDLE.
- Undefined:
  - Strictly one-shot. Only a fresh rising edge of active restarts from IDLE.

Test Plan:
- Reset hold: reset=0 for 4 cycles with active toggling → led=00000 throughout. Release, wait 4 cycles → led stays 00000.
- Single pulse: active=1 for 1 cycle, defaults →
  - led=00001 for 3 cycles, then 00010, 00100, 01000, 10000, 01000, 00100, 00010, 00001, 11111, 00000, 11111, 00000, each for 3 cycles.
  - led=00000 and IDLE at cycle 39.
- Held active (macro undefined): active=1 for 60 cycles → exactly one 39-cycle sequence, then led=00000 until active falls and rises again.
- Retrigger mid-sequence: second pulse at cycle 10 → ignored; sequence timing identical to the single-pulse case.
- Async reset mid-animation: reset=0 between clock edges during SWEEP_R → led=00000 immediately. After release, no animation until a new active rising edge (active=0 during reset).
- LED_ANIM_LOOP_EN defined, active held high → sequence repeats back-to-back: 00001 at cycle 39 and 78. Drop active at cycle 50 → finishes at cycle 78, then idle.
